imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 6: instruction-memory word-address width; DEPTH = 2**ADDR_W words.
REQ-002 Parameter RST_HOLD, default 4: cycles cpu_reset stays high after the last word is written.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  8  boot-stream byte.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
REQ-008 imem_we  output  1  one-cycle write strobe to instruction memory.
REQ-009 imem_addr  output  ADDR_W  word address of the write.
REQ-010 imem_wdata  output  32  instruction word to write.
REQ-011 cpu_reset  output  1  drives the processor's reset port; high holds the core in reset.
REQ-012 done  output  1  load complete and core released.
REQ-013 err  output  1  header length exceeded DEPTH.

Function
REQ-014 Stream format SHALL be: 2-byte word count N (MSB first), then N words of 4 bytes each (MSB first, big-endian MIPS order).
REQ-015 The FSM SHALL have states LEN_HI, LEN_LO, DATA, HOLD, RUN, ERR.
REQ-016 in_ready SHALL be 1 only in LEN_HI, LEN_LO and DATA; otherwise it SHALL be 0.
REQ-017 LEN_HI SHALL capture N[15:8] on a transfer and go to LEN_LO; LEN_LO SHALL capture N[7:0].
REQ-018 From LEN_LO: N == 0 -> HOLD; N > DEPTH -> ERR; otherwise -> DATA with word_cnt = 0 and byte_cnt = 0.
REQ-019 In DATA, each transfer SHALL shift the byte into a 32-bit assembly register; byte_cnt SHALL wrap 3 -> 0.
REQ-020 On the 4th byte of a word, the cycle after the transfer SHALL present imem_we = 1, imem_addr = word_cnt, imem_wdata = assembled word (write latency: 1 cycle).
REQ-021 word_cnt SHALL increment with each write; when the write of word N-1 occurs, the FSM SHALL enter HOLD in that same cycle.
REQ-022 in_ready SHALL remain high in DATA during a write cycle, so back-to-back bytes run at one per cycle without stalls.
REQ-023 HOLD SHALL count RST_HOLD cycles with cpu_reset = 1, then enter RUN.
REQ-024 In RUN, cpu_reset SHALL be 0 and done SHALL be 1 until reset.
REQ-025 In ERR, err SHALL be 1, cpu_reset SHALL be 1, and in_ready SHALL be 0 until reset; no further writes SHALL occur.
REQ-026 cpu_reset SHALL be 1 in every state except RUN.
REQ-027 in_valid low SHALL stall the FSM without changing any counter.
REQ-028 N == DEPTH SHALL be legal and SHALL write addresses 0..DEPTH-1; imem_addr SHALL never wrap.

Reset
REQ-029 reset SHALL synchronously force the state to LEN_HI, all counters and the assembly register to 0, imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_reset = 1, done = 0, err = 0.
REQ-030 Reset during DATA or HOLD SHALL abandon the load; a partially assembled word SHALL NOT be written, and memory contents already written are left unchanged.
REQ-031 Reset SHALL take priority over a simultaneous byte transfer.

Structure
REQ-032 Shared package imem_loader_pkg SHALL hold the state encoding, the default ADDR_W and RST_HOLD values, and the header byte count (2).
REQ-033 A sub-module byte_packer (8-to-32 shift register with byte_cnt and a word_valid pulse) SHALL be instantiated; the FSM and counters remain in imem_loader.

Verification
REQ-034 Stream 00 02 | 3C 08 00 10 | 21 09 00 05 at one byte per cycle -> writes (0, 0x3C080010) and (1, 0x21090005) on consecutive 4-cycle boundaries; cpu_reset falls 4 cycles after the 2nd write; done = 1.
REQ-035 Same stream with in_valid low on alternate cycles -> identical writes and data; only the timing stretches.
REQ-036 Header 00 00 -> no imem_we; HOLD for 4 cycles, then RUN.
REQ-037 Header 00 41 with DEPTH = 64 -> err = 1, in_ready = 0, cpu_reset stays 1, no writes.
REQ-038 Reset asserted after 2 bytes of word 1 -> no write for word 1; a fresh stream 00 01 | DE AD BE EF afterwards writes 0xDEADBEEF at address 0.
REQ-039 Header 00 40 with 64 words whose value equals their index -> last write at address 63 with data 0x0000003F; done = 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and defaults for the boot-stream loader
package imem_loader_pkg;
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, HOLD, RUN, ERR} state_t;
  localparam int ADDR_W_DEF = 6;
  localparam int RST_HOLD_DEF = 4;
  localparam int HDR_BYTES = 2;
  localparam int LEN_W = 8 * HDR_BYTES;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles big-endian bytes into 32-bit words with a one-cycle word_valid pulse
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt,
  output logic        word_valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      byte_cnt <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= en && byte_cnt == 2'd3;
      if (en) begin
        word <= {word[23:0], din};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: parses a length-prefixed boot stream into instruction memory, then releases the core
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RST_HOLD = RST_HOLD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  state_t state, state_n;
  logic [LEN_W-1:0] len, n_next;
  logic [ADDR_W-1:0] word_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0] byte_cnt;
  logic xfer, pack_en, last;
  byte_packer u_packer (
    .clk(clk),
    .rst(reset),
    .en(pack_en),
    .din(in_data),
    .word(imem_wdata),
    .byte_cnt(byte_cnt),
    .word_valid(imem_we)
  );
  // the final word's 4th byte moves straight to HOLD, so its write strobe lands in the first HOLD cycle
  always_comb begin
    in_ready = state inside {LEN_HI, LEN_LO, DATA};
    xfer = in_valid && in_ready;
    pack_en = xfer && state == DATA;
    n_next = {len[LEN_W-9:0], in_data};
    last = pack_en && byte_cnt == 2'd3 && LEN_W'(word_cnt) == len - LEN_W'(1);
    cpu_reset = state != RUN;
    done = state == RUN;
    err = state == ERR;
    imem_addr = word_cnt;
    state_n = state;
    case (state)
      LEN_HI: state_n = xfer ? LEN_LO : LEN_HI;
      LEN_LO: state_n = !xfer ? LEN_LO : n_next == '0 ? HOLD : 32'(n_next) > DEPTH ? ERR : DATA;
      DATA:   state_n = last ? HOLD : DATA;
      HOLD:   state_n = hold_cnt == HOLD_W'(RST_HOLD - 1) ? RUN : HOLD;
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LEN_HI;
      len <= '0;
      word_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_n;
      if (xfer && state != DATA) len <= n_next;
      word_cnt <= state == LEN_LO ? '0 : (imem_we && state == DATA) ? word_cnt + ADDR_W'(1) : word_cnt;
      hold_cnt <= state == HOLD ? hold_cnt + HOLD_W'(1) : '0;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: stream-level model of the loader checked every cycle, plus literal pins per scenario
module tb_imem_loader;
  localparam int ADDR_W = 6;
  localparam int RST_HOLD = 4;
  localparam int DEPTH = 64;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, imem_we, cpu_reset, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  imem_loader #(.ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  int checks = 0, passes = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  // stream-level model: header bytes, data bytes, pending write, hold countdown
  int hdr_got, nval, bytes_got, hold_seen, pend_addr;
  logic [31:0] acc, pend_data;
  bit pend_we, in_hold, run, errd, active, exp_ready, xfer, prev_done;
  int cyc = 0, fall_cyc = 0, hold_cycles = 0;
  int log_addr[$];
  logic [31:0] log_data[$];
  int log_cyc[$];
  always @(negedge clk) begin
    cyc++;
    exp_ready = !errd && !in_hold && !run && (hdr_got < 2 || bytes_got < 4 * nval);
    if (active) begin
      chk("in_ready", in_ready, exp_ready);
      chk("imem_we", imem_we, pend_we);
      if (pend_we) begin
        chk("imem_addr", imem_addr, pend_addr);
        chk("imem_wdata", imem_wdata, pend_data);
      end
      chk("cpu_reset", cpu_reset, !run);
      chk("done", done, run);
      chk("err", err, errd);
    end
    if (imem_we === 1'b1) begin
      log_addr.push_back(int'(imem_addr));
      log_data.push_back(imem_wdata);
      log_cyc.push_back(cyc);
    end
    if (done === 1'b1 && !prev_done) fall_cyc = cyc;
    prev_done = done === 1'b1;
    if (reset) hold_cycles = 0;
    else if (cpu_reset === 1'b1 && in_ready === 1'b0 && err === 1'b0 && done === 1'b0) hold_cycles++;
    if (reset) begin
      hdr_got = 0; nval = 0; bytes_got = 0; hold_seen = 0; acc = 0;
      pend_we = 0; in_hold = 0; run = 0; errd = 0; active = 1;
    end else begin
      xfer = in_valid && exp_ready;
      pend_we = 0;
      if (in_hold) begin
        hold_seen++;
        if (hold_seen == RST_HOLD) begin in_hold = 0; run = 1; end
      end
      if (xfer) begin
        if (hdr_got < 2) begin
          nval = (nval << 8) | int'(in_data);
          hdr_got++;
          if (hdr_got == 2 && nval == 0) begin in_hold = 1; hold_seen = 0; end
          else if (hdr_got == 2 && nval > DEPTH) errd = 1;
        end else begin
          acc = {acc[23:0], in_data};
          bytes_got++;
          if (bytes_got % 4 == 0) begin
            pend_we = 1; pend_addr = bytes_got / 4 - 1; pend_data = acc;
            if (bytes_got == 4 * nval) begin in_hold = 1; hold_seen = 0; end
          end
        end
      end
    end
  end
  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; in_valid = 1'b0;
  endtask
  task automatic idle(input int n, input logic v);
    in_valid = v;
    repeat (n) @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    int k = 0;
    if (gap > 0) idle(gap, 1'b0);
    in_valid = 1'b1; in_data = b;
    @(negedge clk);
    while (in_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk("send_accept", k < 50, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic send_q(input logic [7:0] q[$], input int gap);
    foreach (q[i]) send(q[i], gap);
  endtask
  task automatic wait_end(input int max);
    int k = 0;
    while (done !== 1'b1 && err !== 1'b1 && k < max) begin @(negedge clk); k++; end
    chk("wait_end", k < max, 1);
    idle(2, 1'b0);
  endtask
  logic [7:0] stream[$] = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h10, 8'h21, 8'h09, 8'h00, 8'h05};
  initial begin
    int b;
    logic [7:0] big[$];
    bit ok;
    do_reset();
    chk("reset_cpu_reset", cpu_reset, 1);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_we", imem_we, 0);
    chk("reset_done_err", {done, err}, 0);
    // back-to-back two-word program
    b = log_addr.size();
    send_q(stream, 0);
    wait_end(40);
    chk("t1_nwrites", log_addr.size() - b, 2);
    chk("t1_w0_addr", log_addr[b], 0);
    chk("t1_w0_data", log_data[b], 32'h3C080010);
    chk("t1_w1_addr", log_addr[b+1], 1);
    chk("t1_w1_data", log_data[b+1], 32'h21090005);
    chk("t1_spacing", log_cyc[b+1] - log_cyc[b], 4);
    chk("t1_release", fall_cyc - log_cyc[b+1], RST_HOLD);
    chk("t1_hold_cycles", hold_cycles, RST_HOLD);
    chk("t1_done", {done, cpu_reset}, 2'b10);
    // same stream, valid on alternate cycles
    do_reset();
    b = log_addr.size();
    send_q(stream, 1);
    wait_end(60);
    chk("t2_nwrites", log_addr.size() - b, 2);
    chk("t2_w0_data", log_data[b], 32'h3C080010);
    chk("t2_w1", {log_addr[b+1][7:0], log_data[b+1]}, {8'd1, 32'h21090005});
    chk("t2_spacing", log_cyc[b+1] - log_cyc[b], 8);
    chk("t2_done", done, 1);
    // empty program
    do_reset();
    b = log_addr.size();
    send_q('{8'h00, 8'h00}, 0);
    wait_end(20);
    chk("t3_nwrites", log_addr.size() - b, 0);
    chk("t3_hold_cycles", hold_cycles, RST_HOLD);
    chk("t3_done", {done, cpu_reset}, 2'b10);
    // oversized header
    do_reset();
    b = log_addr.size();
    send_q('{8'h00, 8'h41}, 0);
    in_data = 8'hAA;
    idle(8, 1'b1);
    chk("t4_err", err, 1);
    chk("t4_in_ready", in_ready, 0);
    chk("t4_cpu_reset", {cpu_reset, done}, 2'b10);
    chk("t4_nwrites", log_addr.size() - b, 0);
    // reset mid-word abandons the partial word, then a fresh load
    do_reset();
    b = log_addr.size();
    send_q('{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 0);
    do_reset();
    chk("t5_nwrites_abandon", log_addr.size() - b, 1);
    chk("t5_w0_data", log_data[b], 32'h11223344);
    send_q('{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 0);
    wait_end(30);
    chk("t5_nwrites", log_addr.size() - b, 2);
    chk("t5_fresh", {log_addr[b+1][7:0], log_data[b+1]}, {8'd0, 32'hDEADBEEF});
    chk("t5_done", done, 1);
    // full-depth program, word i holds i
    do_reset();
    b = log_addr.size();
    big = '{8'h00, 8'h40};
    for (int i = 0; i < DEPTH; i++) big = {big, 8'h00, 8'h00, 8'h00, 8'(i)};
    send_q(big, 0);
    wait_end(40);
    chk("t6_nwrites", log_addr.size() - b, DEPTH);
    chk("t6_last_addr", log_addr[b+DEPTH-1], 63);
    chk("t6_last_data", log_data[b+DEPTH-1], 32'h0000003F);
    ok = 1;
    for (int i = 0; i < DEPTH; i++) if (log_addr[b+i] != i || log_data[b+i] != 32'(i)) ok = 0;
    chk("t6_all_words", ok, 1);
    chk("t6_done", {done, cpu_reset, err}, 3'b100);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
